// File: rtl/par8_frame_parser.sv
// Parses opcode/length/payload frames from a byte-strobe receiver into a message buffer,
// presents a valid/ready command and answers each frame with one acknowledge byte.
module par8_frame_parser #(
    parameter int         MAX_LEN = 55,
    parameter logic [7:0] ACK_OK  = 8'hA5,
    parameter logic [7:0] ACK_ERR = 8'hEE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rxd_data,
    input  logic       rxd_data_ready,
    output logic       wr_en,
    output logic [5:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       cmd_valid,
    output logic [7:0] cmd_opcode,
    output logic [6:0] cmd_len,
    input  logic       cmd_ready,
    output logic [7:0] txd_data,
    output logic       txd_valid,
    input  logic       tx_ready_next,
    output logic       overrun
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE,
        GET_LEN,
        GET_PAYLOAD,
        ISSUE,
        ACK_WAIT,
        ACK_SEND
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] opcode_q;
    logic [7:0] len_q;
    logic [7:0] cnt_q;
    logic [7:0] txd_q;
    logic       err_q;
    logic       overrun_q;
    logic       len_err;
    logic       last_byte;
    logic       busy;

    assign len_err   = rxd_data > MAX_LEN_B;
    assign last_byte = cnt_q == (len_q - 8'd1);
    // States in which the parser cannot take a new byte.
    assign busy      = (state == ISSUE) || (state == ACK_WAIT) || (state == ACK_SEND);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rxd_data_ready) state_nxt = GET_LEN;
            end
            GET_LEN: begin
                if (rxd_data_ready) begin
                    if (rxd_data == 8'd0) state_nxt = len_err ? ACK_WAIT : ISSUE;
                    else                  state_nxt = GET_PAYLOAD;
                end
            end
            GET_PAYLOAD: begin
                if (rxd_data_ready && last_byte) state_nxt = err_q ? ACK_WAIT : ISSUE;
            end
            ISSUE: begin
                if (cmd_ready) state_nxt = ACK_WAIT;
            end
            ACK_WAIT: begin
                if (tx_ready_next) state_nxt = ACK_SEND;
            end
            ACK_SEND: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_en     = 1'b0;
        wr_addr   = 6'd0;
        wr_data   = 8'd0;
        cmd_valid = 1'b0;
        txd_valid = 1'b0;
        case (state)
            GET_PAYLOAD: begin
                // Payload bytes go straight through to the buffer in the strobe cycle.
                if (rxd_data_ready && !err_q) begin
                    wr_en   = 1'b1;
                    wr_addr = cnt_q[5:0];
                    wr_data = rxd_data;
                end
            end
            ISSUE:    cmd_valid = 1'b1;
            ACK_SEND: txd_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opcode_q  <= 8'd0;
            len_q     <= 8'd0;
            cnt_q     <= 8'd0;
            err_q     <= 1'b0;
            txd_q     <= 8'd0;
            overrun_q <= 1'b0;
        end else begin
            if (state == IDLE && rxd_data_ready) opcode_q <= rxd_data;
            if (state == GET_LEN && rxd_data_ready) begin
                len_q <= rxd_data;
                cnt_q <= 8'd0;
                err_q <= len_err;
            end
            if (state == GET_PAYLOAD && rxd_data_ready) cnt_q <= cnt_q + 8'd1;
            if (state == ACK_WAIT && tx_ready_next) txd_q <= err_q ? ACK_ERR : ACK_OK;
            if (busy && rxd_data_ready) overrun_q <= 1'b1;
        end
    end

    assign cmd_opcode = opcode_q;
    assign cmd_len    = len_q[6:0];
    assign txd_data   = txd_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_par8_frame_parser.sv
// Randomized frame-level bench for par8_frame_parser with a transaction-level reference model.
module tb_par8_frame_parser;

    localparam logic [7:0] MAX_LEN_TB = 8'd55;
    localparam logic [7:0] ACK_OK_TB  = 8'hA5;
    localparam logic [7:0] ACK_ERR_TB = 8'hEE;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rxd_data;
    logic       rxd_data_ready;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       cmd_valid;
    logic [7:0] cmd_opcode;
    logic [6:0] cmd_len;
    logic       cmd_ready;
    logic [7:0] txd_data;
    logic       txd_valid;
    logic       tx_ready_next;
    logic       overrun;

    int total = 0;
    int bad   = 0;
    bit ovr_exp;
    logic [7:0] pay[$];

    logic [13:0] wq[$];
    logic [14:0] cq[$];
    logic [7:0]  aq[$];
    int          cmd_cycles = 0;
    int          unstable   = 0;
    int          both_high  = 0;
    bit          prev_cv    = 1'b0;
    logic [14:0] prev_cmd   = '0;

    always #5 clk = ~clk;

    par8_frame_parser dut (
        .clk            (clk),
        .reset          (reset),
        .rxd_data       (rxd_data),
        .rxd_data_ready (rxd_data_ready),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .cmd_valid      (cmd_valid),
        .cmd_opcode     (cmd_opcode),
        .cmd_len        (cmd_len),
        .cmd_ready      (cmd_ready),
        .txd_data       (txd_data),
        .txd_valid      (txd_valid),
        .tx_ready_next  (tx_ready_next),
        .overrun        (overrun)
    );

    // Observe transactions at the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_en) wq.push_back({wr_addr, wr_data});
            if (cmd_valid) begin
                cmd_cycles++;
                if (prev_cv && {cmd_opcode, cmd_len} != prev_cmd) unstable++;
            end
            if (cmd_valid && cmd_ready) cq.push_back({cmd_opcode, cmd_len});
            if (txd_valid) aq.push_back(txd_data);
            if ((cmd_valid && txd_valid) || (wr_en && (cmd_valid || txd_valid))) both_high++;
            prev_cv  = cmd_valid;
            prev_cmd = {cmd_opcode, cmd_len};
        end else begin
            prev_cv = 1'b0;
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rxd_data       = b;
        rxd_data_ready = 1'b1;
        @(posedge clk);
        #1;
        rxd_data_ready = 1'b0;
    endtask

    task automatic fill_random(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
    endtask

    // Sends one frame (payload taken from pay) and checks it against the frame-level rules.
    task automatic run_frame(input string nm, input logic [7:0] op, input logic [7:0] len,
                             input int h, input int t, input bit inj, input bit gaps);
        int wb, cb, ab, ccb, nw, k;
        bit legal;
        logic [13:0] wexp;
        logic [7:0]  aexp;
        legal = (len <= MAX_LEN_TB);
        wb = wq.size(); cb = cq.size(); ab = aq.size(); ccb = cmd_cycles;
        cmd_ready     = (h == 0);
        tx_ready_next = (t == 0);
        send_byte(op);
        if (gaps) idle($urandom_range(0, 1));
        send_byte(len);
        for (int i = 0; i < int'(len); i++) begin
            if (gaps) idle($urandom_range(0, 1));
            send_byte(pay[i]);
        end
        if (legal && h > 0) begin
            if (inj) begin
                send_byte(8'($urandom));
                ovr_exp = 1'b1;
                idle(h - 1);
            end else begin
                idle(h);
            end
        end
        cmd_ready = 1'b1;
        if (t > 0) begin
            idle(t);
            total++;
            if (aq.size() != ab) begin
                bad++;
                $display("FAIL %s early_ack got %0d acks want 0", nm, aq.size() - ab);
            end
        end
        tx_ready_next = 1'b1;
        k = 0;
        while (k < 20 && aq.size() == ab) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        idle(2);

        nw = wq.size() - wb;
        total++;
        if (nw != (legal ? int'(len) : 0)) begin
            bad++;
            $display("FAIL %s write_count got %0d want %0d", nm, nw, legal ? int'(len) : 0);
        end
        for (int i = 0; i < nw && legal && i < int'(len); i++) begin
            wexp = {6'(i), pay[i]};
            total++;
            if (wq[wb + i] !== wexp) begin
                bad++;
                $display("FAIL %s write[%0d] got %h want %h", nm, i, wq[wb + i], wexp);
            end
        end
        total++;
        if ((cq.size() - cb) != (legal ? 1 : 0)) begin
            bad++;
            $display("FAIL %s cmd_count got %0d want %0d", nm, cq.size() - cb, legal ? 1 : 0);
        end else if (legal) begin
            total++;
            if (cq[cb] !== {op, len[6:0]}) begin
                bad++;
                $display("FAIL %s cmd_fields got %h want %h", nm, cq[cb], {op, len[6:0]});
            end
        end
        total++;
        if ((cmd_cycles - ccb) != (legal ? h + 1 : 0)) begin
            bad++;
            $display("FAIL %s cmd_valid_cycles got %0d want %0d", nm, cmd_cycles - ccb,
                     legal ? h + 1 : 0);
        end
        aexp = legal ? ACK_OK_TB : ACK_ERR_TB;
        total++;
        if ((aq.size() - ab) != 1) begin
            bad++;
            $display("FAIL %s ack_count got %0d want 1", nm, aq.size() - ab);
        end else begin
            total++;
            if (aq[ab] !== aexp) begin
                bad++;
                $display("FAIL %s ack_byte got %h want %h", nm, aq[ab], aexp);
            end
        end
        total++;
        if (txd_data !== aexp) begin
            bad++;
            $display("FAIL %s txd_hold got %h want %h", nm, txd_data, aexp);
        end
        total++;
        if (overrun !== ovr_exp) begin
            bad++;
            $display("FAIL %s overrun got %b want %b", nm, overrun, ovr_exp);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; rxd_data = 8'd0; rxd_data_ready = 1'b0;
        cmd_ready = 1'b1; tx_ready_next = 1'b1; ovr_exp = 1'b0;
        idle(3);
        @(negedge clk);
        total++;
        if ({wr_en, wr_addr, wr_data, cmd_valid, cmd_opcode, cmd_len,
             txd_data, txd_valid, overrun} !== '0) begin
            bad++;
            $display("FAIL reset_values got wr=%b cv=%b tv=%b op=%h len=%h txd=%h ovr=%b want all 0",
                     wr_en, cmd_valid, txd_valid, cmd_opcode, cmd_len, txd_data, overrun);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_legal;
        pay = '{8'hAA, 8'hBB, 8'hCC};
        run_frame("legal", 8'h01, 8'd3, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_oversize;
        fill_random(56);
        run_frame("oversize", 8'h02, 8'h38, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_zero_len;
        pay.delete();
        run_frame("zero_len", 8'h05, 8'h00, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure;
        fill_random(7);
        run_frame("backpressure", 8'h3C, 8'd7, 10, 5, 1'b0, 1'b1);
        total++;
        if (unstable != 0) begin
            bad++;
            $display("FAIL backpressure_stable got %0d changes want 0", unstable);
        end
    endtask

    task automatic test_overrun;
        fill_random(4);
        run_frame("overrun", 8'h77, 8'd4, 3, 0, 1'b1, 1'b0);
        fill_random(5);
        run_frame("after_overrun", 8'h78, 8'd5, 0, 2, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset;
        int wb, cb, ab;
        fill_random(10);
        send_byte(8'h42);
        send_byte(8'd10);
        for (int i = 0; i < 4; i++) send_byte(pay[i]);
        rxd_data       = 8'h99;
        rxd_data_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({wr_en, wr_addr, wr_data, cmd_valid, cmd_opcode, cmd_len,
             txd_data, txd_valid, overrun} !== '0) begin
            bad++;
            $display("FAIL async_reset got wr=%b op=%h len=%h txd=%h ovr=%b want all 0",
                     wr_en, cmd_opcode, cmd_len, txd_data, overrun);
        end
        rxd_data_ready = 1'b0;
        ovr_exp = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wb = wq.size(); cb = cq.size(); ab = aq.size();
        idle(6);
        total++;
        if (wq.size() != wb || cq.size() != cb || aq.size() != ab) begin
            bad++;
            $display("FAIL abandoned_frame got wr=%0d cmd=%0d ack=%0d want 0 0 0",
                     wq.size() - wb, cq.size() - cb, aq.size() - ab);
        end
        fill_random(6);
        run_frame("after_reset", 8'h43, 8'd6, 1, 1, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        logic [7:0] len;
        for (int f = 0; f < 12; f++) begin
            case ($urandom_range(0, 5))
                0: len = 8'd0;
                1: len = 8'd1;
                2: len = MAX_LEN_TB;
                3: len = MAX_LEN_TB + 8'd1;
                4: len = 8'($urandom_range(0, 80));
                default: len = 8'd255;
            endcase
            fill_random(int'(len));
            run_frame($sformatf("random%0d", f), 8'($urandom), len,
                      $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_legal();
        test_oversize();
        test_zero_len();
        test_backpressure();
        test_overrun();
        test_async_reset();
        test_random();
        total++;
        if (both_high != 0) begin
            bad++;
            $display("FAIL exclusive_outputs got %0d overlaps want 0", both_high);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
